mem_port_arbiter: RTL

- Two-requester arbiter that shares one 32-bit memory port between instruction fetch (requester 0) and load/store (requester 1) in the mips32 datapath.
- Drives `sel` for the 32-bit 2:1 muxes that steer address and write data onto the shared port.
- Latches the winner's request and runs a valid/ready handshake with memory.
- Returns read data with a one-cycle done pulse to the owning requester; round-robin priority prevents starvation.

---
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the shared memory port.
// master is the arbiter's view; slave is the requesters/memory view.
interface mem_port_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0, req1, we1, mem_ready;
   logic [WIDTH-1:0] addr0, addr1, wdata1, mem_rdata;
   logic             done0, done1, sel, busy;
   logic             mem_valid, mem_we, err;
   logic [WIDTH-1:0] rdata, mem_addr, mem_wdata;

   modport master (
      input  req0, addr0, req1, addr1, wdata1, we1,
      input  mem_ready, mem_rdata,
      output done0, done1, rdata, sel, busy,
      output mem_valid, mem_addr, mem_wdata, mem_we, err
   );

   modport slave (
      output req0, addr0, req1, addr1, wdata1, we1,
      output mem_ready, mem_rdata,
      input  done0, done1, rdata, sel, busy,
      input  mem_valid, mem_addr, mem_wdata, mem_we, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port by fetch and load/store.
// Define ARB_TIMEOUT_EN to abort an access after TIMEOUT cycles without mem_ready.
module mem_port_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 4
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t           state;
   logic             last, sel, busy, err;
   logic             done0, done1;
   logic             mem_valid, mem_we;
   logic [WIDTH-1:0] mem_addr, mem_wdata, rdata;

   logic             any_req, win, we_mux;
   logic [WIDTH-1:0] addr_mux, wdata_mux;

   // Under contention the requester not served last wins.
   always_comb begin
      any_req   = bus.req0 | bus.req1;
      win       = (bus.req0 & bus.req1) ? ~last : bus.req1;
      addr_mux  = win ? bus.addr1 : bus.addr0;
      wdata_mux = win ? bus.wdata1 : '0;
      we_mux    = win & bus.we1;
   end

`ifdef ARB_TIMEOUT_EN
   logic [TO_W-1:0] cnt;
   logic            to_hit;
   assign to_hit = (cnt == TO_W'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= 1'b0;
         last      <= 1'b1;
         busy      <= 1'b0;
         err       <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  sel       <= win;
                  mem_addr  <= addr_mux;
                  mem_wdata <= wdata_mux;
                  mem_we    <= we_mux;
                  mem_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ACCESS;
`ifdef ARB_TIMEOUT_EN
                  cnt       <= '0;
`endif
               end
            end
            ACCESS: begin
               // A late mem_ready still wins over the timeout.
               if (bus.mem_ready) begin
                  rdata     <= bus.mem_rdata;
                  mem_valid <= 1'b0;
                  done0     <= ~sel;
                  done1     <= sel;
                  last      <= sel;
                  state     <= DONE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (to_hit) begin
                  rdata     <= '0;
                  mem_valid <= 1'b0;
                  done0     <= ~sel;
                  done1     <= sel;
                  err       <= 1'b1;
                  last      <= sel;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.done0     = done0;
   assign bus.done1     = done1;
   assign bus.rdata     = rdata;
   assign bus.sel       = sel;
   assign bus.busy      = busy;
   assign bus.mem_valid = mem_valid;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_we    = mem_we;
   assign bus.err       = err;
endmodule
